// File: rtl/stream_min_tracker.sv
// Streaming frame minimum tracker: reports the smallest unsigned word of each frame,
// a sticky overflow for frames longer than 65536 beats, and (with STREAM_MIN_TRACKER_INDEX_EN) the beat index.
module stream_min_tracker (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_min,
`ifdef STREAM_MIN_TRACKER_INDEX_EN
    output logic [15:0] out_idx,
`endif
    output logic        out_ovf,
    input  logic        out_ready
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_min_q, out_min_d;
    logic                out_ovf_q, out_ovf_d;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    out_idx_q, out_idx_d;
`endif

    logic                open_c;
    logic                beat_c;
    logic                cnt_sat_c;
    logic [CNT_W-1:0]    beat_idx_c;

    // cnt_q holds the index of the most recent beat; it saturates rather than wraps
    assign open_c     = (state_q != HOLD);
    assign beat_c     = in_valid && open_c;
    assign cnt_sat_c  = (cnt_q == CNT_MAX);
    assign beat_idx_c = cnt_sat_c ? CNT_MAX : cnt_q + CNT_W'(1);

    assign in_ready  = open_c && !rst;
    assign out_valid = out_valid_q;
    assign out_min   = out_min_q;
    assign out_ovf   = out_ovf_q;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
    assign out_idx   = out_idx_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            min_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_ovf_q   <= 1'b0;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
            idx_q       <= '0;
            out_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_min_q   <= out_min_d;
            out_ovf_q   <= out_ovf_d;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
            idx_q       <= idx_d;
            out_idx_q   <= out_idx_d;
`endif
        end
    end

    // Next-state and result register update
    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_min_d   = out_min_q;
        out_ovf_d   = out_ovf_q;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
        idx_d       = idx_q;
        out_idx_d   = out_idx_q;
`endif
        case (state_q)
            IDLE, ACC: begin
                if (beat_c) begin
                    if (state_q == IDLE) begin
                        min_d = in_data;
                        cnt_d = '0;
                        ovf_d = 1'b0;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
                        idx_d = '0;
`endif
                    end else begin
                        cnt_d = beat_idx_c;
                        ovf_d = ovf_q | cnt_sat_c;
                        if (in_data < min_q) begin
                            min_d = in_data;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
                            idx_d = beat_idx_c;
`endif
                        end
                    end
                    if (in_last) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_min_d   = min_d;
                        out_ovf_d   = ovf_d;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
                        out_idx_d   = idx_d;
`endif
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_min_d   = '0;
                    out_ovf_d   = 1'b0;
`ifdef STREAM_MIN_TRACKER_INDEX_EN
                    out_idx_d   = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/stream_min_tracker.md
STREAM_MIN_TRACKER -- requirements
Module: stream_min_tracker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: in_data/in_last valid this cycle.
REQ-004 SHALL have port in_data, input, 32 bits: unsigned word of the current frame.
REQ-005 SHALL have port in_last, input, 1 bit: the current beat is the final beat of its frame.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: frame result available.
REQ-008 SHALL have port out_min, output, 32 bits: minimum unsigned word of the frame.
REQ-009 SHALL have port out_idx, output, 16 bits: zero-based beat index of the minimum (present only with the macro in REQ-027).
REQ-010 SHALL have port out_ovf, output, 1 bit: frame exceeded 65536 beats.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.

Function
REQ-012 SHALL transfer an input beat exactly when in_valid and in_ready are both 1 at a rising clk edge.
REQ-013 SHALL implement states IDLE (no frame open), ACC (frame open), HOLD (result pending); in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-014 SHALL go IDLE->ACC on an accepted beat with in_last=0, IDLE->HOLD on an accepted beat with in_last=1, ACC->HOLD on an accepted beat with in_last=1, and HOLD->IDLE when out_valid and out_ready are 1.
REQ-015 SHALL load the first beat of each frame into the minimum register unconditionally, with index 0.
REQ-016 SHALL replace the minimum on each later beat only when in_data < current minimum (32-bit unsigned strict less-than); on ties the earliest index SHALL be kept.
REQ-017 SHALL keep a 16-bit beat counter that increments per accepted beat, saturates at 0xFFFF, and sets a sticky overflow flag when a beat is accepted with the counter already at 0xFFFF.
REQ-018 SHALL assert out_valid in the cycle after the edge that accepts the in_last beat, with out_min/out_idx including that beat (latency 1 cycle).
REQ-019 SHALL hold out_valid, out_min, out_idx and out_ovf stable in HOLD until the handshake completes.
REQ-020 SHALL drive out_min, out_idx and out_ovf to 0 whenever out_valid is 0.
REQ-021 SHALL NOT accept a beat in the same cycle the result handshake completes; the next frame starts no earlier than the following cycle.
REQ-022 SHALL handle a single-beat frame (first beat with in_last=1) by reporting that word and index 0.
REQ-023 SHALL ignore in_data and in_last when in_valid is 0, including idle gaps inside a frame.

Reset
REQ-024 SHALL, while rst is 1, force state IDLE, in_ready 0, out_valid 0, out_min 0, out_idx 0, out_ovf 0, counter 0, minimum register 0.
REQ-025 SHALL discard any partially accumulated frame or pending result when rst asserts mid-operation; no result for that frame is ever presented.
REQ-026 SHALL drive in_ready to 1 in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL compile port out_idx and its index register only when macro STREAM_MIN_TRACKER_INDEX_EN is defined; without it out_idx SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-028 Frame 7, 3, 9, 3(last), out_ready=1 -> out_valid one cycle after last beat, out_min=3, out_idx=1, out_ovf=0.
REQ-029 Frame 0xFFFFFFFF, 0x80000000, 0x00000001(last) -> out_min=0x00000001, out_idx=2 (confirms unsigned, not signed, comparison).
REQ-030 Single beat 0x1234(last) with out_ready=0 for 5 cycles -> out_valid stays 1, out_min=0x1234, out_idx=0, in_ready=0 throughout; released after out_ready=1.
REQ-031 Frame of 65537 beats of value 5 -> out_min=5, out_idx=0, out_ovf=1; next frame reports out_ovf=0.
REQ-032 rst pulsed after beats 2, 1 of an open frame, then frame 8, 6(last) -> only result out_min=6, out_idx=1.
REQ-033 Build without STREAM_MIN_TRACKER_INDEX_EN, rerun REQ-028 -> out_min=3, identical timing, no out_idx port.
